logic_unit_pipe: RTL and testbench

//   Parametrised, registered bitwise logic unit for the ALU datapath.

---
 rtl/logic_unit_pipe.sv | 128 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Registered bitwise logic unit with valid/ready handshakes on both sides
//   and a single output register. Beats can be folded into one accumulated
//   result (chain mode), e.g. an AND/OR/XOR reduction across words.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   unit can accept a beat this cycle
//   op         0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT a, 7 PASS a
//   a, b       operands (WIDTH bits)
//   chain      beat starts or continues an accumulation chain
//   last       final beat of a chain (ignored when not chaining)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   result     registered result (WIDTH bits)
//   zero       result == 0, registered with result
//   parity     XOR-reduce of result, registered with result
//
// FSM
//   state | meaning
//   IDLE  | no chain open; beats are single ops or start a chain
//   CHAIN | chain open; acc/op_lat hold the running value and latched op

module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             chain,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CHAIN = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op_lat;

    logic             accept;
    logic             load;
    logic             open_chain;
    logic [WIDTH-1:0] beat_val;

    // y is always the newly arriving operand (a), so NOT/PASS act on a both
    // for single beats and inside a chain; x is b or the running accumulator.
    function automatic logic [WIDTH-1:0] f(
        input logic [2:0]       fop,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (fop)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x ^ y);
            3'd4:    r = ~(x & y);
            3'd5:    r = ~(x | y);
            3'd6:    r = ~y;
            default: r = y;
        endcase
        return r;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        beat_val   = '0;
        load       = 1'b0;
        open_chain = 1'b0;
        if (state == CHAIN) begin
            beat_val = f(op_lat, acc, a);
            load     = accept && last;
        end else begin
            beat_val   = f(op, b, a);
            open_chain = accept && chain && !last;
            load       = accept && !(chain && !last);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            op_lat    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            parity    <= 1'b0;
        end else begin
            // A new load wins over a pop in the same cycle.
            if (load) begin
                result    <= beat_val;
                zero      <= ~|beat_val;
                parity    <= ^beat_val;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (open_chain) begin
                acc    <= beat_val;
                op_lat <= op;
                state  <= CHAIN;
            end else if (state == CHAIN && accept) begin
                acc <= beat_val;
                if (last) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
    logic       last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       parity;

    int checks = 0;
    int errors = 0;

    // {result, zero, parity}
    logic [9:0] sb[$];
    logic [9:0] sb_exp;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .chain     (chain),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] pack(input logic [7:0] r);
        return {r, (r == 8'h00), ^r};
    endfunction

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return x ~^ y;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    // Scoreboard: pop on every output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got result=%h, required no output", result);
            end else begin
                sb_exp = sb.pop_front();
                if ({result, zero, parity} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: got %h z=%b p=%b, required %h z=%b p=%b",
                             result, zero, parity, sb_exp[9:2], sb_exp[1], sb_exp[0]);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic l);
        int guard = 0;
        op = o; a = x; b = y; chain = c; last = l; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 0; op = 0; a = 0; b = 0; chain = 0; last = 0; out_ready = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, result, zero, parity, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_init: got v=%b r=%h z=%b p=%b rdy=%b, required v=0 r=00 z=0 p=0 rdy=1",
                     out_valid, result, zero, parity, in_ready);
        end
        rst_n = 1;
        @(negedge clk);
        sb.push_back(pack(8'h03));
        send(3'd1, 8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        send(3'd2, 8'h33, 8'h22, 1'b1, 1'b0);
        rst_n = 0;
        #1;
        checks++;
        if ({out_valid, result, zero, parity} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_midchain: got v=%b r=%h z=%b p=%b, required v=0 r=00 z=0 p=0",
                     out_valid, result, zero, parity);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        sb.push_back(pack(8'h30));
        send(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0);
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h30}) begin
            errors++;
            $display("FAIL reset_after_beat: got v=%b r=%h, required v=1 r=30", out_valid, result);
        end
        @(negedge clk);
    endtask

    task automatic test_single_ops;
        logic [7:0] tbl [8];
        tbl = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'h0F, 8'hF0};
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            sb.push_back({tbl[i], 1'b0, 1'b0});
            send(3'(i), 8'hF0, 8'h3C, 1'b0, 1'b0);
            checks++;
            if ({out_valid, result, zero, parity} !== {1'b1, tbl[i], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL single_op%0d: got v=%b r=%h z=%b p=%b, required v=1 r=%h z=0 p=0",
                         i, out_valid, result, zero, parity, tbl[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        out_ready = 1;
        sb.push_back({8'h00, 1'b1, 1'b0});
        send(3'd0, 8'hAA, 8'h55, 1'b0, 1'b0);
        checks++;
        if ({result, zero, parity} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_flag: got r=%h z=%b p=%b, required r=00 z=1 p=0", result, zero, parity);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        sb.push_back(pack(8'hFF));
        send(3'd1, 8'h0F, 8'hF0, 1'b0, 1'b0);
        op = 3'd0; a = 8'hFF; b = 8'h3C; chain = 0; last = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 8'hFF}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b r=%h, required v=1 rdy=0 r=ff",
                         i, out_valid, in_ready, result);
            end
            @(negedge clk);
        end
        sb.push_back(pack(8'h3C));
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL bp_second: got v=%b r=%h, required v=1 r=3c", out_valid, result);
        end
        @(negedge clk);
    endtask

    task automatic test_chain_xor;
        out_ready = 1;
        send(3'd2, 8'h11, 8'h22, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL chain_xor_beat1: got out_valid=%b, required 0", out_valid);
        end
        send(3'd0, 8'h44, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL chain_xor_beat2: got out_valid=%b, required 0", out_valid);
        end
        sb.push_back({8'hFF, 1'b0, 1'b0});
        send(3'd7, 8'h88, 8'h5A, 1'b1, 1'b1);
        checks++;
        if ({out_valid, result, parity} !== {1'b1, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL chain_xor_out: got v=%b r=%h p=%b, required v=1 r=ff p=0",
                     out_valid, result, parity);
        end
        @(negedge clk);
    endtask

    task automatic test_chain_gaps;
        out_ready = 1;
        send(3'd0, 8'hFF, 8'h0F, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL chain_gap_hold: got out_valid=%b, required 0", out_valid);
        end
        sb.push_back(pack(8'h0C));
        send(3'd5, 8'h3C, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h0C}) begin
            errors++;
            $display("FAIL chain_gap_out: got v=%b r=%h, required v=1 r=0c", out_valid, result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [2:0] o;
        logic [7:0] x;
        logic [7:0] y;
        logic       pending;
        int         sent;
        int         guard;
        pending = 0; sent = 0; guard = 0;
        o = 0; x = 0; y = 0;
        while (sent < 24 && guard < 500) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                o = 3'($urandom_range(0, 7));
                x = 8'($urandom);
                y = 8'($urandom);
                pending = 1;
            end
            op = o; a = x; b = y; chain = 0; last = 0; in_valid = 1;
            #1;
            if (in_ready) begin
                sb.push_back(pack(model(o, x, y)));
                pending = 0;
                sent++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 0;
        out_ready = 1;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb.size() != 0 || sent != 24) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending, %0d sent, required 0 pending, 24 sent",
                     sb.size(), sent);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_ops();
        test_zero();
        test_backpressure();
        test_chain_xor();
        test_chain_gaps();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
